// File: rtl/axi4_burst_master.sv
// AXI4 burst master: INCR bursts of 1..2^LEN_WIDTH beats.
// Read and write sides are independent FSMs that can run at the same time.
// Read beats are streamed out registered; write beats pass straight through
// from the request side to the W channel.
module axi4_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int RESP_WIDTH = 2,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  iClock,
  input  logic                  iReset,
  // read request side
  input  logic                  iRdValid,
  output logic                  oRdReady,
  input  logic [ADDR_WIDTH-1:0] iRdAddr,
  input  logic [LEN_WIDTH-1:0]  iRdLen,
  input  logic [2:0]            iRdSize,
  output logic                  oRdDataValid,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oRdDataLast,
  output logic                  oRdDone,
  output logic [RESP_WIDTH-1:0] oRdResp,
  // write request side
  input  logic                  iWrValid,
  output logic                  oWrReady,
  input  logic [ADDR_WIDTH-1:0] iWrAddr,
  input  logic [LEN_WIDTH-1:0]  iWrLen,
  input  logic [2:0]            iWrSize,
  input  logic                  iWrDataValid,
  output logic                  oWrDataReady,
  input  logic [DATA_WIDTH-1:0] iWrData,
  input  logic [MASK_WIDTH-1:0] iWrMask,
  output logic                  oWrDone,
  output logic [RESP_WIDTH-1:0] oWrResp,
  // AR
  input  logic                  pAXI4_ar_ready,
  output logic                  pAXI4_ar_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
  output logic [LEN_WIDTH-1:0]  pAXI4_ar_bits_len,
  output logic [2:0]            pAXI4_ar_bits_size,
  output logic [1:0]            pAXI4_ar_bits_burst,
  // R
  input  logic                  pAXI4_r_valid,
  input  logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
  input  logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
  input  logic                  pAXI4_r_bits_last,
  output logic                  pAXI4_r_ready,
  // AW
  input  logic                  pAXI4_aw_ready,
  output logic                  pAXI4_aw_valid,
  output logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
  output logic [LEN_WIDTH-1:0]  pAXI4_aw_bits_len,
  output logic [2:0]            pAXI4_aw_bits_size,
  output logic [1:0]            pAXI4_aw_bits_burst,
  // W
  input  logic                  pAXI4_w_ready,
  output logic                  pAXI4_w_valid,
  output logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
  output logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
  output logic                  pAXI4_w_bits_last,
  // B
  input  logic                  pAXI4_b_valid,
  input  logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp,
  output logic                  pAXI4_b_ready
);

  localparam logic [1:0]            BURST_INCR = 2'b01;
  localparam logic [RESP_WIDTH-1:0] RESP_SLV   = RESP_WIDTH'(2);
  localparam logic [LEN_WIDTH:0]    CNT_ONE    = (LEN_WIDTH+1)'(1);

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t r_rd_state, w_rd_next;
  wr_state_t r_wr_state, w_wr_next;

  // Readies stay low through reset and rise one cycle after release.
  logic r_alive;

  logic [ADDR_WIDTH-1:0] r_ar_addr, r_aw_addr;
  logic [LEN_WIDTH-1:0]  r_ar_len, r_aw_len;
  logic [2:0]            r_ar_size, r_aw_size;
  // One bit wider than len so a full 2^LEN_WIDTH-beat burst never wraps.
  logic [LEN_WIDTH:0]    r_rd_cnt, r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_dvalid, r_rd_last, r_rd_done, r_wr_done;
  logic [RESP_WIDTH-1:0] r_rd_resp, r_wr_resp;

  logic w_rd_accept, w_ar_hs, w_r_hs, w_rd_at_len, w_rd_end_beat;
  logic w_wr_accept, w_aw_hs, w_w_hs, w_b_hs, w_wr_at_len;

  assign w_rd_accept   = iRdValid && oRdReady;
  assign w_ar_hs       = pAXI4_ar_valid && pAXI4_ar_ready;
  assign w_r_hs        = pAXI4_r_valid && pAXI4_r_ready;
  assign w_rd_at_len   = (r_rd_cnt == {1'b0, r_ar_len});
  // Whichever comes first, the counter or the slave's last flag, ends it.
  assign w_rd_end_beat = w_rd_at_len || pAXI4_r_bits_last;

  assign w_wr_accept   = iWrValid && oWrReady;
  assign w_aw_hs       = pAXI4_aw_valid && pAXI4_aw_ready;
  assign w_w_hs        = pAXI4_w_valid && pAXI4_w_ready;
  assign w_b_hs        = pAXI4_b_valid && pAXI4_b_ready;
  assign w_wr_at_len   = (r_wr_cnt == {1'b0, r_aw_len});

  assign pAXI4_ar_bits_addr  = r_ar_addr;
  assign pAXI4_ar_bits_len   = r_ar_len;
  assign pAXI4_ar_bits_size  = r_ar_size;
  assign pAXI4_ar_bits_burst = BURST_INCR;
  assign pAXI4_aw_bits_addr  = r_aw_addr;
  assign pAXI4_aw_bits_len   = r_aw_len;
  assign pAXI4_aw_bits_size  = r_aw_size;
  assign pAXI4_aw_bits_burst = BURST_INCR;
  assign pAXI4_w_bits_data   = iWrData;
  assign pAXI4_w_bits_strb   = iWrMask;

  assign oRdData      = r_rd_data;
  assign oRdDataValid = r_rd_dvalid;
  assign oRdDataLast  = r_rd_last;
  assign oRdDone      = r_rd_done;
  assign oRdResp      = r_rd_resp;
  assign oWrDone      = r_wr_done;
  assign oWrResp      = r_wr_resp;

  // State registers and the out-of-reset flag.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_rd_state <= RD_IDLE;
      r_wr_state <= WR_IDLE;
      r_alive    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
      r_alive    <= 1'b1;
    end
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    w_rd_next      = r_rd_state;
    oRdReady       = 1'b0;
    pAXI4_ar_valid = 1'b0;
    pAXI4_r_ready  = 1'b0;
    unique case (r_rd_state)
      RD_IDLE: begin
        oRdReady = r_alive;
        if (w_rd_accept) w_rd_next = RD_AR;
      end
      RD_AR: begin
        pAXI4_ar_valid = 1'b1;
        if (w_ar_hs) w_rd_next = RD_DATA;
      end
      RD_DATA: begin
        pAXI4_r_ready = 1'b1;
        if (w_r_hs && w_rd_end_beat) w_rd_next = RD_IDLE;
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // Write FSM next state; W is only exposed in DATA so it cannot lead AW.
  always_comb begin
    w_wr_next         = r_wr_state;
    oWrReady          = 1'b0;
    pAXI4_aw_valid    = 1'b0;
    pAXI4_w_valid     = 1'b0;
    pAXI4_w_bits_last = 1'b0;
    oWrDataReady      = 1'b0;
    pAXI4_b_ready     = 1'b0;
    unique case (r_wr_state)
      WR_IDLE: begin
        oWrReady = r_alive;
        if (w_wr_accept) w_wr_next = WR_AW;
      end
      WR_AW: begin
        pAXI4_aw_valid = 1'b1;
        if (w_aw_hs) w_wr_next = WR_DATA;
      end
      WR_DATA: begin
        pAXI4_w_valid     = iWrDataValid;
        pAXI4_w_bits_last = w_wr_at_len;
        oWrDataReady      = pAXI4_w_ready;
        if (w_w_hs && w_wr_at_len) w_wr_next = WR_RESP;
      end
      WR_RESP: begin
        pAXI4_b_ready = 1'b1;
        if (w_b_hs) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // Read datapath: request latch, beat capture, burst response tracking.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_ar_addr   <= '0;
      r_ar_len    <= '0;
      r_ar_size   <= '0;
      r_rd_cnt    <= '0;
      r_rd_data   <= '0;
      r_rd_dvalid <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_rd_resp   <= '0;
    end else begin
      r_rd_dvalid <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_done   <= 1'b0;
      if (w_rd_accept) begin
        r_ar_addr <= iRdAddr;
        r_ar_len  <= iRdLen;
        r_ar_size <= iRdSize;
        r_rd_cnt  <= '0;
        r_rd_resp <= '0;
      end
      if (w_r_hs) begin
        r_rd_data   <= pAXI4_r_bits_data;
        r_rd_dvalid <= 1'b1;
        r_rd_cnt    <= r_rd_cnt + CNT_ONE;
        r_rd_last   <= w_rd_end_beat;
        r_rd_done   <= w_rd_end_beat;
        // First error sticks; a last/length disagreement reports SLVERR.
        if (r_rd_resp == '0) begin
          if (pAXI4_r_bits_resp != '0)
            r_rd_resp <= pAXI4_r_bits_resp;
          else if (w_rd_at_len != pAXI4_r_bits_last)
            r_rd_resp <= RESP_SLV;
        end
      end
    end
  end

  // Write datapath: request latch, beat counting, B response capture.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_aw_size <= '0;
      r_wr_cnt  <= '0;
      r_wr_done <= 1'b0;
      r_wr_resp <= '0;
    end else begin
      r_wr_done <= 1'b0;
      if (w_wr_accept) begin
        r_aw_addr <= iWrAddr;
        r_aw_len  <= iWrLen;
        r_aw_size <= iWrSize;
        r_wr_cnt  <= '0;
      end
      if (w_w_hs) r_wr_cnt <= r_wr_cnt + CNT_ONE;
      if (w_b_hs) begin
        r_wr_resp <= pAXI4_b_bits_resp;
        r_wr_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: table of read bursts, hand-written write,
// concurrent and reset sequences; beats are checked through scoreboards.
module tb_axi4_burst_master;

  logic        iClock, iReset;
  logic        iRdValid, oRdReady;
  logic [31:0] iRdAddr;
  logic [7:0]  iRdLen;
  logic [2:0]  iRdSize;
  logic        oRdDataValid, oRdDataLast, oRdDone;
  logic [63:0] oRdData;
  logic [1:0]  oRdResp;
  logic        iWrValid, oWrReady;
  logic [31:0] iWrAddr;
  logic [7:0]  iWrLen;
  logic [2:0]  iWrSize;
  logic        iWrDataValid, oWrDataReady, oWrDone;
  logic [63:0] iWrData;
  logic [7:0]  iWrMask;
  logic [1:0]  oWrResp;
  logic        pAXI4_ar_ready, pAXI4_ar_valid;
  logic [31:0] pAXI4_ar_bits_addr;
  logic [7:0]  pAXI4_ar_bits_len;
  logic [2:0]  pAXI4_ar_bits_size;
  logic [1:0]  pAXI4_ar_bits_burst;
  logic        pAXI4_r_valid, pAXI4_r_bits_last, pAXI4_r_ready;
  logic [63:0] pAXI4_r_bits_data;
  logic [1:0]  pAXI4_r_bits_resp;
  logic        pAXI4_aw_ready, pAXI4_aw_valid;
  logic [31:0] pAXI4_aw_bits_addr;
  logic [7:0]  pAXI4_aw_bits_len;
  logic [2:0]  pAXI4_aw_bits_size;
  logic [1:0]  pAXI4_aw_bits_burst;
  logic        pAXI4_w_ready, pAXI4_w_valid, pAXI4_w_bits_last;
  logic [63:0] pAXI4_w_bits_data;
  logic [7:0]  pAXI4_w_bits_strb;
  logic        pAXI4_b_valid, pAXI4_b_ready;
  logic [1:0]  pAXI4_b_bits_resp;

  axi4_burst_master dut (
    .iClock(iClock), .iReset(iReset),
    .iRdValid(iRdValid), .oRdReady(oRdReady), .iRdAddr(iRdAddr), .iRdLen(iRdLen),
    .iRdSize(iRdSize), .oRdDataValid(oRdDataValid), .oRdData(oRdData),
    .oRdDataLast(oRdDataLast), .oRdDone(oRdDone), .oRdResp(oRdResp),
    .iWrValid(iWrValid), .oWrReady(oWrReady), .iWrAddr(iWrAddr), .iWrLen(iWrLen),
    .iWrSize(iWrSize), .iWrDataValid(iWrDataValid), .oWrDataReady(oWrDataReady),
    .iWrData(iWrData), .iWrMask(iWrMask), .oWrDone(oWrDone), .oWrResp(oWrResp),
    .pAXI4_ar_ready(pAXI4_ar_ready), .pAXI4_ar_valid(pAXI4_ar_valid),
    .pAXI4_ar_bits_addr(pAXI4_ar_bits_addr), .pAXI4_ar_bits_len(pAXI4_ar_bits_len),
    .pAXI4_ar_bits_size(pAXI4_ar_bits_size), .pAXI4_ar_bits_burst(pAXI4_ar_bits_burst),
    .pAXI4_r_valid(pAXI4_r_valid), .pAXI4_r_bits_data(pAXI4_r_bits_data),
    .pAXI4_r_bits_resp(pAXI4_r_bits_resp), .pAXI4_r_bits_last(pAXI4_r_bits_last),
    .pAXI4_r_ready(pAXI4_r_ready),
    .pAXI4_aw_ready(pAXI4_aw_ready), .pAXI4_aw_valid(pAXI4_aw_valid),
    .pAXI4_aw_bits_addr(pAXI4_aw_bits_addr), .pAXI4_aw_bits_len(pAXI4_aw_bits_len),
    .pAXI4_aw_bits_size(pAXI4_aw_bits_size), .pAXI4_aw_bits_burst(pAXI4_aw_bits_burst),
    .pAXI4_w_ready(pAXI4_w_ready), .pAXI4_w_valid(pAXI4_w_valid),
    .pAXI4_w_bits_data(pAXI4_w_bits_data), .pAXI4_w_bits_strb(pAXI4_w_bits_strb),
    .pAXI4_w_bits_last(pAXI4_w_bits_last),
    .pAXI4_b_valid(pAXI4_b_valid), .pAXI4_b_bits_resp(pAXI4_b_bits_resp),
    .pAXI4_b_ready(pAXI4_b_ready)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          ar_dly;
    int          nbeats;    // expected delivered beats
    int          last_at;   // beat index where slave raises r_last, -1 never
    int          err_at;    // beat index carrying err_resp, -1 none
    logic [1:0]  err_resp;
    bit          gap;       // idle cycle before every odd beat
    bit          poke;      // re-assert iRdValid while busy
    logic [63:0] data0;
    logic [1:0]  exp_resp;
  } rd_vec_t;

  typedef struct { logic [63:0] data; logic last; } rbeat_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } wbeat_t;

  rbeat_t rd_q[$];
  wbeat_t wr_q[$];
  int checks = 0, failures = 0;
  int rd_done_cnt = 0, wr_done_cnt = 0, rd_beats = 0;
  bit aw_hs_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [63:0] wdata(input int b);
    return 64'hC0DE_0000_0000_0000 | 64'(b);
  endfunction

  function automatic logic [7:0] wmask(input int b);
    return (b % 2 == 0) ? 8'h0F : 8'hF0;
  endfunction

  // Monitor: scoreboard pops for R/W beats, W-before-AW guard, done counts.
  always @(negedge iClock) begin
    rbeat_t re;
    wbeat_t we;
    if (pAXI4_w_valid) check("w_after_aw", aw_hs_seen, 1);
    if (pAXI4_aw_valid && pAXI4_aw_ready) aw_hs_seen = 1'b1;
    if (pAXI4_w_valid && pAXI4_w_ready) begin
      if (wr_q.size() == 0) check("w_unexpected", 1, 0);
      else begin
        we = wr_q.pop_front();
        check("w_data", pAXI4_w_bits_data, we.data);
        check("w_strb", pAXI4_w_bits_strb, we.strb);
        check("w_last", pAXI4_w_bits_last, we.last);
      end
    end
    if (oRdDataValid) begin
      rd_beats++;
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        re = rd_q.pop_front();
        check("rd_data", oRdData, re.data);
        check("rd_last", oRdDataLast, re.last);
      end
    end
    if (oRdDone) begin
      rd_done_cnt++;
      check("rd_done_with_last", oRdDataValid & oRdDataLast, 1);
    end
    if (oWrDone) wr_done_cnt++;
  end

  task automatic run_read(input rd_vec_t v);
    int d0, b0, to;
    rbeat_t e;
    d0 = rd_done_cnt;
    b0 = rd_beats;
    iRdAddr = v.addr; iRdLen = v.len; iRdSize = v.size; iRdValid = 1'b1;
    #1 check("rd_req_ready", oRdReady, 1);
    step();
    iRdValid = 1'b0;
    check("ar_valid", pAXI4_ar_valid, 1);
    for (int k = 0; k < v.ar_dly; k++) begin
      if (v.poke && k == 0) begin
        iRdValid = 1'b1; iRdAddr = ~v.addr;
        #1 check("rd_busy_ready", oRdReady, 0);
      end
      step();
    end
    iRdValid = 1'b0; iRdAddr = v.addr;
    check("ar_addr", pAXI4_ar_bits_addr, v.addr);
    check("ar_len", pAXI4_ar_bits_len, v.len);
    check("ar_size", pAXI4_ar_bits_size, v.size);
    check("ar_burst", pAXI4_ar_bits_burst, 2'b01);
    pAXI4_ar_ready = 1'b1;
    step();
    pAXI4_ar_ready = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      if (v.gap && (i % 2 == 1)) step();
      pAXI4_r_valid     = 1'b1;
      pAXI4_r_bits_data = v.data0 + 64'(i);
      pAXI4_r_bits_last = (i == v.last_at);
      pAXI4_r_bits_resp = (i == v.err_at) ? v.err_resp : 2'b00;
      e.data = v.data0 + 64'(i);
      e.last = (i == v.nbeats - 1);
      rd_q.push_back(e);
      check("r_ready", pAXI4_r_ready, 1);
      step();
      pAXI4_r_valid = 1'b0; pAXI4_r_bits_last = 1'b0; pAXI4_r_bits_resp = 2'b00;
    end
    to = 0;
    while (rd_done_cnt == d0 && to < 20) begin step(); to++; end
    check("rd_done_count", rd_done_cnt - d0, 1);
    check("rd_beat_count", rd_beats - b0, v.nbeats);
    check("rd_resp", oRdResp, v.exp_resp);
    if (v.poke) begin
      repeat (3) step();
      check("rd_no_second_ar", pAXI4_ar_valid, 0);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] bresp, input int aw_dly);
    wbeat_t e;
    iWrAddr = addr; iWrLen = len; iWrSize = 3'd3; iWrValid = 1'b1;
    aw_hs_seen = 1'b0;
    // Data offered early: it must not appear on W until AW completes.
    iWrDataValid = 1'b1; iWrData = wdata(0); iWrMask = wmask(0);
    #1 check("wr_req_ready", oWrReady, 1);
    step();
    iWrValid = 1'b0;
    check("aw_valid", pAXI4_aw_valid, 1);
    for (int k = 0; k < aw_dly; k++) begin
      check("w_gated_pre_aw", pAXI4_w_valid, 0);
      step();
    end
    check("aw_addr", pAXI4_aw_bits_addr, addr);
    check("aw_len", pAXI4_aw_bits_len, len);
    check("aw_size", pAXI4_aw_bits_size, 3'd3);
    check("aw_burst", pAXI4_aw_bits_burst, 2'b01);
    pAXI4_aw_ready = 1'b1;
    #1 check("w_gated_aw_hs", pAXI4_w_valid, 0);
    step();
    pAXI4_aw_ready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      iWrData = wdata(b); iWrMask = wmask(b); iWrDataValid = 1'b1;
      pAXI4_w_ready = 1'b0;
      #1;
      check("w_valid", pAXI4_w_valid, 1);
      check("w_data_pass", pAXI4_w_bits_data, wdata(b));
      check("w_strb_pass", pAXI4_w_bits_strb, wmask(b));
      check("w_last_stall", pAXI4_w_bits_last, b == int'(len));
      check("wr_dready_stall", oWrDataReady, 0);
      step();
      e.data = wdata(b); e.strb = wmask(b); e.last = (b == int'(len));
      wr_q.push_back(e);
      pAXI4_w_ready = 1'b1;
      #1 check("wr_dready", oWrDataReady, 1);
      step();
      pAXI4_w_ready = 1'b0;
    end
    iWrDataValid = 1'b0;
    check("b_ready", pAXI4_b_ready, 1);
    check("wr_done_early", oWrDone, 0);
    pAXI4_b_valid = 1'b1; pAXI4_b_bits_resp = bresp;
    step();
    pAXI4_b_valid = 1'b0; pAXI4_b_bits_resp = 2'b00;
    check("wr_done", oWrDone, 1);
    check("wr_resp", oWrResp, bresp);
    check("wr_ready_after", oWrReady, 1);
    step();
    check("wr_done_pulse", oWrDone, 0);
  endtask

  rd_vec_t vecs[7];
  rd_vec_t crd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dr, dw;
    wbeat_t e;
    vecs[0] = '{32'h8000_0000, 8'd0,   3'd3, 2, 1,   0,   -1, 2'b00, 1'b0, 1'b0, 64'h1122334455667788, 2'b00};
    vecs[1] = '{32'h0000_1000, 8'd3,   3'd3, 0, 4,   3,   -1, 2'b00, 1'b1, 1'b0, 64'hA000_0000_0000_0000, 2'b00};
    vecs[2] = '{32'h0000_2000, 8'd2,   3'd3, 1, 2,   1,   -1, 2'b00, 1'b0, 1'b0, 64'hB000_0000_0000_0000, 2'b10};
    vecs[3] = '{32'h0000_3000, 8'd2,   3'd3, 0, 3,   2,    0, 2'b11, 1'b0, 1'b0, 64'hC000_0000_0000_0000, 2'b11};
    vecs[4] = '{32'h0000_4000, 8'd1,   3'd3, 0, 2,   -1,  -1, 2'b00, 1'b0, 1'b0, 64'hD000_0000_0000_0000, 2'b10};
    vecs[5] = '{32'h0000_5004, 8'd0,   3'd2, 1, 1,   0,    0, 2'b01, 1'b1, 1'b0, 64'hE000_0000_0000_0000, 2'b01};
    vecs[6] = '{32'h0001_0000, 8'd255, 3'd3, 0, 256, 255, -1, 2'b00, 1'b0, 1'b0, 64'h7000_0000_0000_0000, 2'b00};
    crd     = '{32'h0000_6000, 8'd1,   3'd3, 3, 2,   1,   -1, 2'b00, 1'b0, 1'b1, 64'hF000_0000_0000_0000, 2'b00};

    iReset = 1'b1;
    iRdValid = 0; iRdAddr = 0; iRdLen = 0; iRdSize = 0;
    iWrValid = 0; iWrAddr = 0; iWrLen = 0; iWrSize = 0;
    iWrDataValid = 0; iWrData = 0; iWrMask = 0;
    pAXI4_ar_ready = 0; pAXI4_r_valid = 0; pAXI4_r_bits_data = 0;
    pAXI4_r_bits_resp = 0; pAXI4_r_bits_last = 0;
    pAXI4_aw_ready = 0; pAXI4_w_ready = 0; pAXI4_b_valid = 0; pAXI4_b_bits_resp = 0;
    repeat (3) step();
    check("rst_rd_ready", oRdReady, 0);
    check("rst_wr_ready", oWrReady, 0);
    check("rst_ar_valid", pAXI4_ar_valid, 0);
    check("rst_aw_valid", pAXI4_aw_valid, 0);
    check("rst_rd_dvalid", oRdDataValid, 0);
    check("rst_ar_addr", pAXI4_ar_bits_addr, 0);
    check("rst_rd_resp", oRdResp, 0);
    check("rst_wr_resp", oWrResp, 0);
    iReset = 1'b0;
    step();
    check("rel_rd_ready", oRdReady, 1);
    check("rel_wr_ready", oWrReady, 1);

    for (int i = 0; i < 7; i++) run_read(vecs[i]);

    run_write(32'h9000_0000, 8'd1, 2'b00, 2);
    run_write(32'h9000_0100, 8'd0, 2'b10, 0);

    dr = rd_done_cnt; dw = wr_done_cnt;
    fork
      run_read(crd);
      run_write(32'h0000_A000, 8'd1, 2'b00, 1);
    join
    check("conc_rd_done", rd_done_cnt - dr, 1);
    check("conc_wr_done", wr_done_cnt - dw, 1);

    // Reset in the middle of a write burst.
    iWrAddr = 32'h0000_B000; iWrLen = 8'd3; iWrSize = 3'd3; iWrValid = 1'b1;
    aw_hs_seen = 1'b0;
    step();
    iWrValid = 1'b0;
    pAXI4_aw_ready = 1'b1;
    step();
    pAXI4_aw_ready = 1'b0;
    iWrDataValid = 1'b1; iWrData = wdata(0); iWrMask = wmask(0);
    e.data = wdata(0); e.strb = wmask(0); e.last = 1'b0;
    wr_q.push_back(e);
    pAXI4_w_ready = 1'b1;
    step();
    pAXI4_w_ready = 1'b0;
    dw = wr_done_cnt;
    iReset = 1'b1;
    step();
    pAXI4_w_ready = 1'b1;
    #1;
    check("mid_rst_aw_valid", pAXI4_aw_valid, 0);
    check("mid_rst_w_valid", pAXI4_w_valid, 0);
    check("mid_rst_w_last", pAXI4_w_bits_last, 0);
    check("mid_rst_dready", oWrDataReady, 0);
    check("mid_rst_b_ready", pAXI4_b_ready, 0);
    check("mid_rst_wr_done", oWrDone, 0);
    check("mid_rst_wr_ready", oWrReady, 0);
    iReset = 1'b0; iWrDataValid = 1'b0; pAXI4_w_ready = 1'b0;
    step();
    check("post_rst_wr_ready", oWrReady, 1);
    repeat (3) step();
    check("post_rst_no_done", wr_done_cnt - dw, 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Parametrised AXI4 (full) master. Successor to the single-beat AXI4-Lite master.
- Adds INCR bursts of 1..2^LEN_WIDTH beats, a configurable beat size, per-beat streaming of read and write data, and burst-level response reporting.
- Sits between the core's LSU/IFU request side and the SoC crossbar.
- Read and write channels run as independent FSMs and may be active concurrently.

Parameters:
- ADDR_WIDTH, 32, address width of AR/AW.
- DATA_WIDTH, 64, data bus width; MASK_WIDTH = DATA_WIDTH/8 is derived.
- LEN_WIDTH, 8, width of burst length field; beats per burst = len+1.
- RESP_WIDTH, 2, AXI response width.

Ports:
- iClock in 1: clock.
- iReset in 1: synchronous active-high reset.
- iRdValid in 1: read request; accepted when iRdValid && oRdReady.
- oRdReady out 1: read FSM idle.
- iRdAddr in ADDR_WIDTH: read start address.
- iRdLen in LEN_WIDTH: read burst length (beats - 1).
- iRdSize in 3: read beat size, log2 bytes.
- oRdDataValid out 1: one read beat delivered.
- oRdData out DATA_WIDTH: read beat data.
- oRdDataLast out 1: final beat of the read burst.
- oRdDone out 1: read burst complete.
- oRdResp out RESP_WIDTH: burst-level read response.
- iWrValid in 1: write request; accepted when iWrValid && oWrReady.
- oWrReady out 1: write FSM idle.
- iWrAddr in ADDR_WIDTH: write start address.
- iWrLen in LEN_WIDTH: write burst length (beats - 1).
- iWrSize in 3: write beat size, log2 bytes.
- iWrDataValid in 1: write beat available.
- oWrDataReady out 1: write beat consumed this cycle.
- iWrData in DATA_WIDTH: write beat data.
- iWrMask in MASK_WIDTH: write byte strobes.
- oWrDone out 1: write burst complete.
- oWrResp out RESP_WIDTH: write response.
- AXI AR channel:
  - pAXI4_ar_ready in 1.
  - pAXI4_ar_valid out 1.
  - pAXI4_ar_bits_addr out ADDR_WIDTH.
  - pAXI4_ar_bits_len out LEN_WIDTH.
  - pAXI4_ar_bits_size out 3.
  - pAXI4_ar_bits_burst out 2.
- AXI R channel:
  - pAXI4_r_valid in 1.
  - pAXI4_r_bits_data in DATA_WIDTH.
  - pAXI4_r_bits_resp in RESP_WIDTH.
  - pAXI4_r_bits_last in 1.
  - pAXI4_r_ready out 1.
- AXI AW channel: pAXI4_aw_ready in 1; pAXI4_aw_valid out 1; pAXI4_aw_bits_addr out ADDR_WIDTH; pAXI4_aw_bits_len out LEN_WIDTH; pAXI4_aw_bits_size out 3; pAXI4_aw_bits_burst out 2.
- AXI W channel: pAXI4_w_ready in 1; pAXI4_w_valid out 1; pAXI4_w_bits_data out DATA_WIDTH; pAXI4_w_bits_strb out MASK_WIDTH; pAXI4_w_bits_last out 1.
- AXI B channel: pAXI4_b_valid in 1; pAXI4_b_bits_resp in RESP_WIDTH; pAXI4_b_ready out 1.

Behaviour:
- Reset (synchronous, active-high, checked at the clock edge):
  - Both FSMs go to IDLE and beat counters clear.
  - All valid/ready/done/last outputs are 0; oRdReady and oWrReady become 1 the cycle after reset deasserts.
  - Registered addr/len/size/data/resp outputs are 0.
  - Reset mid-burst abandons the transaction with no done pulse.
- Burst type: ar_bits_burst and aw_bits_burst are constant 2'b01 (INCR).
- Read FSM, IDLE -> AR -> DATA -> IDLE:
  - IDLE: on request accept, latch addr/len/size into the AR registers, set ar_valid, go to AR.
  - AR: hold ar_valid and all AR fields stable until ar handshake; then clear ar_valid and go to DATA.
  - DATA: r_ready=1 (consumer cannot backpressure).
  - Each r handshake registers data into oRdData and pulses oRdDataValid for 1 cycle the following cycle; the beat counter increments.
  - The burst ends on the beat where counter==len OR r_last=1, whichever comes first.
  - On the ending beat, oRdDataLast=1 together with that beat's oRdDataValid, oRdDone pulses in the same cycle, and the FSM returns to IDLE.
  - oRdResp = first non-zero beat resp of the burst, else 2'b00.
  - Mismatch between r_last and the counter (r_last early, or counter==len with r_last=0) forces oRdResp=2'b10 unless an error is already captured.
  - oRdResp holds until the next accepted read.
- Write FSM, IDLE -> AW -> DATA -> RESP -> IDLE:
  - IDLE: on request accept, latch addr/len/size, set aw_valid, go to AW.
  - AW: hold until aw handshake, then go to DATA. W is never asserted before the AW handshake.
  - DATA: w_valid=iWrDataValid, w_bits_data=iWrData, w_bits_strb=iWrMask (all combinational), w_bits_last=(counter==len), oWrDataReady=w_ready.
  - Each w handshake increments the counter; after the handshake with last=1, go to RESP.
  - RESP: b_ready=1; on b handshake, oWrResp<=b_resp, oWrDone pulses the next cycle, go to IDLE.
- Channel independence: read and write FSMs are fully independent; simultaneous accepts are legal.
- Request acceptance: requests are accepted only in IDLE; iRdValid/iWrValid while busy is ignored (no queueing).
- Length and counter width: len=0 gives a single-beat burst. Counters are LEN_WIDTH+1 bits, so len=2^LEN_WIDTH-1 does not wrap.

Test Plan:
- Single read, addr 0x8000_0000, len 0, size 3. Slave returns ar_ready after 2 cycles, then r data 0x1122334455667788, last=1, resp 0. Required: one oRdDataValid with that data, oRdDataLast=1, oRdDone pulse, oRdResp=0.
- Read len 3 with r_valid gaps. Required: exactly 4 oRdDataValid pulses in order, last on 4th beat only, ar_len=3, ar_burst=1.
- Write len 1, strb 0x0F then 0xF0, with w_ready stalls. Required: w_last only on the 2nd beat, no w_valid before aw handshake, oWrDone 1 cycle after b handshake, oWrResp=0.
- Read len 2 where the slave asserts r_last on beat 2 with resp 0. Required: burst ends at beat 2, oRdResp=2'b10. A separate burst with beat resp 2'b11 on beat 1 is followed by 0s. Required: oRdResp=2'b11.
- Concurrent read len 1 and write len 1 accepted in the same cycle. Required: both complete and both done pulses are seen. iRdValid reasserted mid-burst is ignored.
- Reset asserted during the write DATA state. Required: the next cycle has aw/w/b valid and ready outputs at 0, no oWrDone, oWrReady=1 after release.
